qif_neuron_scheduler: RTL and testbench
=======================================

Name: qif_neuron_scheduler

Overview:
Time-multiplexes one 8-bit signed QIF membrane-update datapath across N_NEURONS virtual neurons.
- Holds per-neuron membrane state and synaptic-current accumulators.
- Sweeps all neurons once per timestep and emits spike events through a small FIFO with valid/ready.
- Sits between the synaptic input fabric and the spike router; replaces N parallel QIF neuron instances.

Parameters:
N_NEURONS, 8, number of virtual neurons
IDX_W, 3, neuron index width (clog2 N_NEURONS)
V_PEAK, 50, signed spike threshold
V_RESET, -20, signed post-spike membrane value
SQ_SHIFT, 7, right-shift applied to V*V (quadratic gain)
SPK_FIFO_DEPTH, 4, spike event FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
enable  in  1  level; allows starting a new timestep sweep
i_valid  in  1  synaptic input valid
i_ready  out  1  synaptic input ready
i_idx  in  IDX_W  target neuron of input
i_syn  in  8  signed synaptic current contribution
spk_valid  out  1  spike event valid
spk_ready  in  1  spike consumer ready
spk_idx  out  IDX_W  index of spiking neuron (FIFO head)
mon_idx  in  IDX_W  monitor select
v_mon  out  8  signed membrane of neuron mon_idx (combinational read)
step_done  out  1  one-cycle pulse at sweep end
spk_overflow  out  1  sticky: spike dropped on full FIFO

Behaviour:
- Reset (async, rst_n=1): all V[] = 0, all acc[] = 0, FSM = IDLE, FIFO empty, spk_valid = 0, step_done = 0, spk_overflow = 0, i_ready = 0, v_mon = 0.
- i_ready = 1 in every cycle outside reset.
- Input accept on i_valid & i_ready: acc[i_idx] <= sat8(acc[i_idx] + i_syn).
- Input accept, i_idx >= N_NEURONS: input dropped.
- FSM states IDLE, LOAD, UPDATE, WRITE.
  - IDLE -> LOAD when enable=1; cur = 0.
  - LOAD: latch v = V[cur] and a = acc[cur].
  - UPDATE: sq = v*v (16b unsigned); dv = (sq >> SQ_SHIFT) + a, computed at 10b signed; vn = sat8(v + dv) to [-128, 127]; spike = (vn >= V_PEAK), signed compare.
  - WRITE: V[cur] <= spike ? V_RESET : vn; acc[cur] cleared; on spike, push cur into FIFO.
  - WRITE, cur < N-1: cur++, go to LOAD.
  - WRITE, cur = N-1: step_done = 1 next cycle, go to IDLE.
- Latency: 3 cycles per neuron; sweep = 3*N_NEURONS cycles (24 default). step_done asserts the cycle after the last WRITE. Back-to-back sweeps add 1 IDLE cycle.
- Input accepted for cur in the same cycle as its WRITE: acc[cur] <= sat8(i_syn), not cleared. The contribution counts toward the next timestep and is never lost. Input to cur accepted during LOAD/UPDATE is also deferred this way (acc already latched).
- enable deasserted mid-sweep: the sweep completes; no new sweep starts.
- Spike FIFO:
  - spk_valid = !empty; pop on spk_valid & spk_ready.
  - Push and pop in the same cycle: allowed when full.
  - Push when full and no pop: event dropped, spk_overflow set (cleared only by reset); the neuron is still reset to V_RESET.
- Reset asserted mid-sweep: immediate return to reset state; partial sweep discarded.

Optional Feature:
QIF_LEAK_EN
- Defined: UPDATE uses dv = (sq >> SQ_SHIFT) + a - (v >>> 3), arithmetic shift, i.e. linear leak toward 0.
- Undefined: no leak term; behaviour exactly as above.
- Test values below assume undefined.

Test Plan:
- Reset: assert rst_n mid-sweep -> spk_valid=0, step_done=0, v_mon=0 for every mon_idx; FSM IDLE after release.
- Sub-threshold: acc[2]=30, one sweep -> V[2]=30, no spike, step_done exactly 24 cycles after start.
- Spike: second sweep with acc[2]=30 (V=30: 900>>7=7; 30+7+30=67) -> V[2]=-20, spk_idx=2 with spk_valid=1.
- Collision: i_syn=10 to neuron 5 in its WRITE cycle -> acc[5]=10 after WRITE; V[5] picks it up next sweep.
- Saturation: acc[0] gets +100 twice -> acc=127. V=127 with acc=127 -> vn=127, spike.
- FIFO overflow: all 8 neurons spike, spk_ready=0 -> 4 events queued (idx 0..3), spk_overflow=1, all V=-20; drain yields 0,1,2,3.

Source files
------------

// File: rtl/qif_neuron_scheduler.sv
// One 8-bit signed QIF membrane datapath time-shared across N_NEURONS virtual neurons.
// Define QIF_LEAK_EN to add a linear leak term, -(v >>> 3), to the membrane update.
module qif_neuron_scheduler #(
    parameter int N_NEURONS      = 8,
    parameter int IDX_W          = 3,
    parameter int V_PEAK         = 50,
    parameter int V_RESET        = -20,
    parameter int SQ_SHIFT       = 7,
    parameter int SPK_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic signed [7:0]       i_syn,
    output logic                    spk_valid,
    input  logic                    spk_ready,
    output logic [IDX_W-1:0]        spk_idx,
    input  logic [IDX_W-1:0]        mon_idx,
    output logic signed [7:0]       v_mon,
    output logic                    step_done,
    output logic                    spk_overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    localparam int                PTR_W  = $clog2(SPK_FIFO_DEPTH);
    localparam logic [IDX_W:0]    N_LIM  = (IDX_W+1)'(N_NEURONS);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(N_NEURONS - 1);
    localparam logic [PTR_W:0]    F_FULL = (PTR_W+1)'(SPK_FIFO_DEPTH);
    localparam logic signed [7:0] PEAK8  = 8'(V_PEAK);
    localparam logic signed [7:0] RST8   = 8'(V_RESET);

    logic signed [7:0]  v_mem   [N_NEURONS];
    logic signed [7:0]  acc_mem [N_NEURONS];
    logic [1:0]         state;
    logic [IDX_W-1:0]   cur;
    logic signed [7:0]  v_r, a_r, vn_r;
    logic               spk_r;

    logic [IDX_W-1:0]   fifo [SPK_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop, push_ok, in_hit, in_cur;

    logic signed [15:0] v16;
    logic [15:0]        sq, sq_sh;
    logic signed [9:0]  dv, sum;
    logic signed [7:0]  vn;

    function automatic logic signed [7:0] sat8(input logic signed [8:0] x);
        if (x > 9'sd127)       return 8'sd127;
        else if (x < -9'sd128) return -8'sd128;
        else                   return x[7:0];
    endfunction

    assign i_ready = !rst_n;
    assign in_hit  = i_valid && i_ready && ({1'b0, i_idx} < N_LIM);
    assign in_cur  = in_hit && (i_idx == cur) && (state == S_LOAD);
    assign v_mon   = ({1'b0, mon_idx} < N_LIM) ? v_mem[mon_idx] : '0;

    always_comb begin
        v16   = 16'(v_r);
        sq    = $unsigned(v16 * v16);
        sq_sh = sq >> SQ_SHIFT;
        dv    = $signed(10'(sq_sh)) + 10'(a_r);
`ifdef QIF_LEAK_EN
        dv    = dv - 10'(v_r >>> 3);
`else
        dv    = dv;
`endif
        sum   = 10'(v_r) + dv;
        if (sum > 10'sd127)       vn = 8'sd127;
        else if (sum < -10'sd128) vn = -8'sd128;
        else                      vn = sum[7:0];
    end

    // The accumulator is consumed when LOAD latches it, so any input arriving for
    // cur after that point (LOAD, UPDATE or WRITE) stays banked for the next step.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned k = 0; k < N_NEURONS; k++) begin
                v_mem[k]   <= '0;
                acc_mem[k] <= '0;
            end
            state     <= S_IDLE;
            cur       <= '0;
            v_r       <= '0;
            a_r       <= '0;
            vn_r      <= '0;
            spk_r     <= 1'b0;
            step_done <= 1'b0;
        end else begin
            step_done <= (state == S_WRITE) && (cur == LAST);
            if (state == S_LOAD)
                acc_mem[cur] <= in_cur ? i_syn : '0;
            if (in_hit && !in_cur)
                acc_mem[i_idx] <= sat8(9'(acc_mem[i_idx]) + 9'(i_syn));
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_LOAD;
                        cur   <= '0;
                    end
                end
                S_LOAD: begin
                    v_r   <= v_mem[cur];
                    a_r   <= acc_mem[cur];
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    vn_r  <= vn;
                    spk_r <= (vn >= PEAK8);
                    state <= S_WRITE;
                end
                default: begin
                    v_mem[cur] <= spk_r ? RST8 : vn_r;
                    if (cur == LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cur   <= cur + 1'b1;
                        state <= S_LOAD;
                    end
                end
            endcase
        end
    end

    assign spk_valid = (count != '0);
    assign spk_idx   = fifo[rd_ptr];
    assign push      = (state == S_WRITE) && spk_r;
    assign pop       = spk_valid && spk_ready;
    assign push_ok   = push && ((count != F_FULL) || pop);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned k = 0; k < SPK_FIFO_DEPTH; k++)
                fifo[k] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            spk_overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
                fifo[wr_ptr] <= cur;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (push && !push_ok)
                spk_overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Self-checking bench for qif_neuron_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a schedule-based reference model.
module tb_qif_neuron_scheduler;

    localparam int N  = 8;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 enable = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 spk_ready = 1'b0;
    logic [IW-1:0]        i_idx = '0;
    logic [IW-1:0]        mon_idx = '0;
    logic signed [7:0]    i_syn = '0;
    logic                 i_ready, spk_valid, step_done, spk_overflow;
    logic [IW-1:0]        spk_idx;
    logic signed [7:0]    v_mon;

    int vectors = 0;
    int errors  = 0;

    qif_neuron_scheduler #(
        .N_NEURONS(8), .IDX_W(3), .V_PEAK(50), .V_RESET(-20),
        .SQ_SHIFT(7), .SPK_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .i_valid(i_valid), .i_ready(i_ready), .i_idx(i_idx), .i_syn(i_syn),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
        .mon_idx(mon_idx), .v_mon(v_mon),
        .step_done(step_done), .spk_overflow(spk_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: neuron k is latched 3k+1 edges and written 3k+3 edges after the start edge.
    int mv   [N];
    int macc [N];
    int q [$];
    bit movf    = 1'b0;
    bit mdone   = 1'b0;
    int sweep_t = -1;
    int pend_vn = 0;
    bit pend_spk = 1'b0;

    function automatic int sat8(input int x);
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                mv[k]   = 0;
                macc[k] = 0;
            end
            q.delete();
            movf    = 1'b0;
            mdone   = 1'b0;
            sweep_t = -1;
        end else begin
            int s, lk, wk;
            bit popm;
            lk    = -1;
            wk    = -1;
            popm  = (q.size() > 0) && spk_ready;
            mdone = 1'b0;
            if (sweep_t >= 0) begin
                s = sweep_t + 1;
                if (s % 3 == 1)      lk = s / 3;
                else if (s % 3 == 0) wk = s / 3 - 1;
                if (wk == N - 1) begin
                    sweep_t = -1;
                    mdone   = 1'b1;
                end else begin
                    sweep_t = s;
                end
            end else if (enable) begin
                sweep_t = 0;
            end
            if (lk >= 0) begin
                pend_vn  = sat8(mv[lk] + (mv[lk] * mv[lk]) / 128 + macc[lk]);
                pend_spk = (pend_vn >= 50);
                macc[lk] = 0;
            end
            if (i_valid)
                macc[int'(i_idx)] = sat8(macc[int'(i_idx)] + int'(i_syn));
            if (popm)
                void'(q.pop_front());
            if (wk >= 0) begin
                mv[wk] = pend_spk ? -20 : pend_vn;
                if (pend_spk) begin
                    if (q.size() < 4) q.push_back(wk);
                    else              movf = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("i_ready", int'(i_ready), rst_n ? 0 : 1);
        check("spk_valid", int'(spk_valid), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0)
            check("spk_idx", int'(spk_idx), q[0]);
        check("step_done", int'(step_done), int'(mdone));
        check("spk_overflow", int'(spk_overflow), int'(movf));
        check("v_mon", int'(v_mon), mv[int'(mon_idx)]);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input int idx, input int syn);
        i_valid = 1'b1;
        i_idx   = IW'(idx);
        i_syn   = 8'(syn);
        tick;
        i_valid = 1'b0;
    endtask

    task automatic chk_v(input int idx, input int exp, input string nm);
        mon_idx = IW'(idx);
        tick;
        check(nm, int'(v_mon), exp);
    endtask

    task automatic run_sweep(input int inj_at, input int inj_idx, input int inj_syn);
        int n;
        enable = 1'b1;
        tick;
        enable = 1'b0;
        n = 0;
        while (n < 100) begin
            if (n + 1 == inj_at) begin
                i_valid = 1'b1;
                i_idx   = IW'(inj_idx);
                i_syn   = 8'(inj_syn);
            end
            tick;
            n++;
            i_valid = 1'b0;
            if (step_done) break;
        end
        check("sweep_len", n, 24);
    endtask

    task automatic drain_one;
        spk_ready = 1'b1;
        tick;
        spk_ready = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        check("reset_v_mon", int'(v_mon), 0);
        check("reset_i_ready", int'(i_ready), 0);
        rst_n = 1'b0;
        tick;

        // sub-threshold: V[2] = 0 + 0 + 30
        feed(2, 30);
        run_sweep(0, 0, 0);
        chk_v(2, 30, "subthr_v2");
        check("model_v2", mv[2], 30);
        check("subthr_nospike", int'(spk_valid), 0);

        // spike: 30 + 900/128 + 30 = 67 >= 50
        feed(2, 30);
        run_sweep(0, 0, 0);
        chk_v(2, -20, "spike_v2");
        check("spike_valid", int'(spk_valid), 1);
        check("spike_idx", int'(spk_idx), 2);
        check("model_qsize", q.size(), 1);
        drain_one;
        check("spike_drained", int'(spk_valid), 0);

        // collision: input to neuron 5 on its WRITE edge (3*5+3) lands next step
        run_sweep(18, 5, 10);
        chk_v(5, 0, "coll_v5_first");
        run_sweep(0, 0, 0);
        chk_v(5, 10, "coll_v5_next");

        // reset mid-sweep
        enable = 1'b1;
        tick;
        enable = 1'b0;
        repeat (10) tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < N; i++) chk_v(i, 0, "midrst_v_mon");
        check("midrst_spk_valid", int'(spk_valid), 0);
        check("midrst_step_done", int'(step_done), 0);
        rst_n = 1'b0;
        tick;
        run_sweep(0, 0, 0);

        // saturation: +100 twice -> 127 -> spike; -100 twice -> -128, V=-20+3-128 -> -128
        feed(0, 100);
        feed(0, 100);
        run_sweep(0, 0, 0);
        chk_v(0, -20, "sat_pos_v0");
        check("sat_pos_idx", int'(spk_idx), 0);
        check("sat_pos_valid", int'(spk_valid), 1);
        drain_one;
        feed(0, -100);
        feed(0, -100);
        run_sweep(0, 0, 0);
        chk_v(0, -128, "sat_neg_v0");
        check("model_v0", mv[0], -128);

        // overflow: all eight spike with consumer stalled
        rst_n = 1'b1;
        tick;
        rst_n = 1'b0;
        tick;
        for (int i = 0; i < N; i++) feed(i, 127);
        run_sweep(0, 0, 0);
        check("ovf_flag", int'(spk_overflow), 1);
        for (int i = 0; i < N; i++) chk_v(i, -20, "ovf_v");
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_valid", int'(spk_valid), 1);
            check("ovf_drain_idx", int'(spk_idx), i);
            drain_one;
        end
        check("ovf_empty", int'(spk_valid), 0);
        check("ovf_sticky", int'(spk_overflow), 1);

        // randomized traffic
        rst_n = 1'b1;
        tick;
        rst_n = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 599) == 0);
            enable    = ($urandom_range(0, 9) < 7);
            i_valid   = ($urandom_range(0, 1) == 1);
            i_idx     = IW'($urandom_range(0, N - 1));
            i_syn     = 8'($urandom);
            spk_ready = ($urandom_range(0, 2) != 0);
            mon_idx   = IW'($urandom_range(0, N - 1));
            tick;
        end
        rst_n   = 1'b0;
        enable  = 1'b0;
        i_valid = 1'b0;
        repeat (3) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
